// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the pipeline skid register.
package pipe_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  // Occupancy state: no entries, main only, or main plus skid.
  typedef logic [1:0] pipe_state_t;
  localparam pipe_state_t ST_EMPTY = 2'd0;
  localparam pipe_state_t ST_MAIN  = 2'd1;
  localparam pipe_state_t ST_SKID  = 2'd2;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// Upstream/downstream handshake bundle for pipe_skid_reg.
interface pipe_skid_reg_if #(
  parameter int DATA_W = pipe_pkg::DATA_W_DEF,
  parameter int CNT_W  = pipe_pkg::CNT_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  // master drives the stage, slave is the stage itself
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, stall_cnt);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, stall_cnt);
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) with flush and a
// saturating stall counter. in_ready is decoded from registered state
// only, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_skid_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_t       r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_cnt;

  logic w_out_valid;
  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_ready  = (r_state != ST_SKID);
  assign w_in_xfer   = bus.in_valid & w_in_ready;
  assign w_out_xfer  = w_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign bus.stall_cnt = r_cnt;

  // Occupancy FSM and payload movement; reset beats flush beats transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
      if (ZERO_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= bus.in_data;
            r_state <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= bus.in_data;
          end else if (w_in_xfer) begin
            // downstream stalled: park the new entry behind main
            r_skid  <= bus.in_data;
            r_state <= ST_SKID;
          end else if (w_out_xfer) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_state <= ST_MAIN;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Saturating count of stalled cycles; flush does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then a random run, all
// checked against a queue-based model of the two-entry stage.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(64), .CNT_W(16)) bus_a ();
  pipe_skid_reg_if #(.DATA_W(64), .CNT_W(3))  bus_s ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.out_ready = out_ready;

  pipe_skid_reg #(.DATA_W(64), .CNT_W(16), .ZERO_ON_FLUSH(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_a.slave));

  pipe_skid_reg #(.DATA_W(64), .CNT_W(3), .ZERO_ON_FLUSH(1'b1)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_s.slave));

  // reference model: FIFO of held entries (capacity 2)
  logic [63:0] q[$];
  int unsigned cnt_a, cnt_s;
  bit          zero_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // compare current outputs, apply inputs for one cycle, advance the model
  task automatic step(bit rst, bit fl, bit iv, logic [63:0] d, bit ordy);
    bit in_x, out_x, stall;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    chk("in_ready",  64'(bus_a.in_ready),  64'(q.size() < 2));
    chk("out_valid", 64'(bus_a.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("out_data", bus_a.out_data, q[0]);
    else if (zero_exp) chk("out_data_zero", bus_a.out_data, 64'd0);
    chk("stall_cnt", 64'(bus_a.stall_cnt), 64'(cnt_a));
    chk("sat_cnt",   64'(bus_s.stall_cnt), 64'(cnt_s));
    chk("sat_valid", 64'(bus_s.out_valid), 64'(q.size() > 0));
    in_x  = iv && (q.size() < 2);
    out_x = (q.size() > 0) && ordy;
    stall = (q.size() > 0) && !ordy;
    @(posedge clk); #1;
    if (rst) begin
      q.delete(); cnt_a = 0; cnt_s = 0; zero_exp = 1'b1;
    end else begin
      if (stall) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_s < 7) cnt_s++;
      end
      if (fl) begin
        q.delete(); zero_exp = 1'b1;
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) begin q.push_back(d); zero_exp = 1'b0; end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); cnt_a = 0; cnt_s = 0; zero_exp = 1'b1;

    // reset state, then streaming 1..4 with out_ready high
    step(1, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 64'(i), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // skid fill: 0xA into main, stall, push 0xB into skid, then release
    step(0, 0, 1, 64'hA, 0);
    step(0, 0, 1, 64'hB, 0);
    chk("skid_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("skid_head",     bus_a.out_data,      64'hA);
    step(0, 0, 1, 64'hC, 0);            // refused: stage is full
    step(0, 0, 0, 0, 1);
    chk("skid_second",   bus_a.out_data,      64'hB);
    step(0, 0, 0, 0, 1);

    // flush collision while full
    step(0, 0, 1, 64'h11, 0);
    step(0, 0, 1, 64'h22, 0);
    step(0, 1, 1, 64'h33, 1);
    chk("flush_valid", 64'(bus_a.out_valid), 64'd0);
    chk("flush_data",  bus_a.out_data,       64'd0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // saturation of the 3-bit counter, held across flush, cleared by reset
    step(0, 0, 1, 64'h55, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("sat_hold", 64'(bus_s.stall_cnt), 64'd7);
    step(0, 1, 0, 0, 0);
    chk("sat_after_flush", 64'(bus_s.stall_cnt), 64'd7);
    step(1, 0, 0, 0, 0);
    chk("sat_after_reset", 64'(bus_s.stall_cnt), 64'd0);

    // reset while full, then first push appears after one cycle
    step(0, 0, 1, 64'h66, 0);
    step(0, 0, 1, 64'h77, 0);
    step(1, 0, 1, 64'h88, 1);
    chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_data",  bus_a.out_data,       64'd0);
    chk("rst_cnt",   64'(bus_a.stall_cnt), 64'd0);
    step(0, 0, 1, 64'h99, 0);
    chk("rst_push", bus_a.out_data, 64'h99);
    step(0, 0, 0, 0, 1);

    // random traffic with phases of varying backpressure
    for (int i = 0; i < 10000; i++) begin
      int unsigned rdy_pct;
      rdy_pct = ((i / 500) % 3 == 0) ? 90 : (((i / 500) % 3 == 1) ? 50 : 20);
      step(($urandom_range(999) == 0),
           ($urandom_range(99) < 3),
           ($urandom_range(99) < 60),
           {$urandom, $urandom},
           ($urandom_range(99) < rdy_pct));
    end
    step(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
